instr_fetch: RTL

Instruction-fetch (IF) stage of the 5-stage MIPS R2000 pipeline, directly upstream of decode. It owns the PC register, issues word requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register (instruction + PC+4) consumed by decode. It obeys decode's hazard-unit stalls (`hold_pc`, `hold_if`) and branch redirect (`br`, `pc_branch`). A one-entry skid buffer and a drain state keep the memory handshake legal under stalls and branches.

---
 rtl/instr_fetch.sv | 128 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// MIPS R2000 instruction-fetch stage: owns the PC, runs the imem req/ack
// handshake and drives the IF/ID register, with a one-entry skid and a drain state.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_pc,
  input  logic        hold_if,
  input  logic        br,
  input  logic [31:0] pc_branch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {FETCH, FULL, DRAIN} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_redirectPc;
  logic [31:0] r_skidInst;
  logic [31:0] r_skidPc4;
  logic        r_outstanding;
  logic [31:0] r_inst;
  logic [31:0] r_pcOut;
  logic        r_valid;

  logic        w_req;
  logic        w_ack;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_target;

  // A raised request must stay up until acked, so hold_pc only gates new ones.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      FETCH:   w_req = r_outstanding | ~hold_pc;
      DRAIN:   w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  assign w_ack     = imem_ack & w_req;
  assign w_pcPlus4 = r_pc + 32'd4;
  assign w_target  = {pc_branch[31:2], 2'b00};

  assign imem_req  = w_req & rst_n;
  assign imem_addr = r_pc;
  assign inst_out  = r_inst;
  assign pc_out    = r_pcOut;
  assign valid_out = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_redirectPc  <= RESET_PC;
      r_skidInst    <= 32'h0;
      r_skidPc4     <= 32'h0;
      r_outstanding <= 1'b0;
      r_inst        <= 32'h0;
      r_pcOut       <= 32'h0;
      r_valid       <= 1'b0;
    end else if (br && !hold_if) begin
      r_inst     <= 32'h0;
      r_pcOut    <= 32'h0;
      r_valid    <= 1'b0;
      r_skidInst <= 32'h0;
      r_skidPc4  <= 32'h0;
      // An unacked request cannot be withdrawn; park the target until it drains.
      if (r_state == FETCH && w_req && !imem_ack) begin
        r_redirectPc  <= w_target;
        r_outstanding <= 1'b1;
        r_state       <= DRAIN;
      end else if (r_state == DRAIN && !imem_ack) begin
        r_redirectPc <= w_target;
      end else begin
        r_pc          <= w_target;
        r_outstanding <= 1'b0;
        r_state       <= FETCH;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (w_ack) begin
            r_pc          <= w_pcPlus4;
            r_outstanding <= 1'b0;
            if (hold_if) begin
              r_skidInst <= imem_rdata;
              r_skidPc4  <= w_pcPlus4;
              r_state    <= FULL;
            end else begin
              r_inst  <= imem_rdata;
              r_pcOut <= w_pcPlus4;
              r_valid <= 1'b1;
            end
          end else begin
            r_outstanding <= w_req;
            if (!hold_if) r_valid <= 1'b0;
          end
        end
        FULL: begin
          if (!hold_if) begin
            r_inst  <= r_skidInst;
            r_pcOut <= r_skidPc4;
            r_valid <= 1'b1;
            r_state <= FETCH;
          end
        end
        DRAIN: begin
          if (!hold_if) r_valid <= 1'b0;
          if (w_ack) begin
            r_pc          <= r_redirectPc;
            r_outstanding <= 1'b0;
            r_state       <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule
